sort_mem_arbiter: RTL and testbench
===================================

Name: sort_mem_arbiter

Overview:
- Shares the single-port sort array memory between the bubble-sort controller (sorter) and the host load/unload port.
- Sorter has default priority. A host starvation counter guarantees bounded host latency.
- A sorter lock keeps read/compare/write pairs (t1/t2) atomic, and a lock watchdog recovers a stuck lock.
- Sits between the sort datapath address/data muxes and the memory array.

Parameters:
- DATAWIDTH, 32, memory word width
- ADDRWIDTH, 8, memory address width
- MAX_WAIT, 8, host wait cycles (range 1..255) after which the host wins the next unlocked cycle
- LOCK_MAX, 16, maximum consecutive cycles in SORT_LOCKED before forced release

Ports:
- c_clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- h_req  in  1  host request
- h_wen  in  1  host write (1) / read (0)
- h_addr  in  ADDRWIDTH  host address
- h_wdata  in  DATAWIDTH  host write data
- h_gnt  out  1  host granted this cycle
- h_rdata  out  DATAWIDTH  host read data
- h_rvalid  out  1  h_rdata valid
- s_req  in  1  sorter request
- s_wen  in  1  sorter write/read
- s_lock  in  1  sorter requests ownership beyond this transfer
- s_addr  in  ADDRWIDTH  sorter address
- s_wdata  in  DATAWIDTH  sorter write data
- s_gnt  out  1  sorter granted this cycle
- s_rdata  out  DATAWIDTH  sorter read data
- s_rvalid  out  1  s_rdata valid
- m_ren  out  1  memory read enable
- m_wen  out  1  memory write enable
- m_addr  out  ADDRWIDTH  memory address
- m_wdata  out  DATAWIDTH  memory write data
- m_rdata  in  DATAWIDTH  memory read data, valid the cycle after m_ren
- lock_err  out  1  sticky: lock watchdog fired
- h_gnt_cnt  out  16  host grant count (optional feature)
- s_gnt_cnt  out  16  sorter grant count (optional feature)

Behaviour:
- Reset values:
  - state=IDLE; wait_cnt=0; lock_cnt=0; rd_own=NONE.
  - All gnt, rvalid, m_ren, m_wen, lock_err and counters = 0.
  - m_addr and m_wdata are 0 when no grant is active.
- Handshake:
  - A requester holds req/wen/addr/wdata stable until it sees gnt=1.
  - Transfer completes on the rising edge where gnt=1.
  - gnt is combinational from state, requests and counters. At most one gnt per cycle.
- Memory mux: m_* are driven combinationally from the granted requester. m_ren = gnt & ~wen; m_wen = gnt & wen.
- Read return:
  - rd_own registers the owner of each granted read.
  - The next cycle, the owner's rvalid=1 and its rdata = m_rdata. The other rdata is 0.
  - Latency is 1 cycle; back-to-back reads are allowed.
- States: IDLE, SORT, HOST, SORT_LOCKED.
- Grant rules, evaluated in order:
  1. SORT_LOCKED: only the sorter may be granted. h_gnt=0 regardless of wait_cnt.
  2. h_req & (wait_cnt >= MAX_WAIT): host wins.
  3. s_req: sorter wins.
  4. h_req: host wins.
- Next state:
  - Host granted -> HOST.
  - Sorter granted with s_lock=1 -> SORT_LOCKED.
  - Sorter granted with s_lock=0 -> SORT.
  - No grant -> IDLE, except from SORT_LOCKED.
  - SORT_LOCKED stays SORT_LOCKED while s_lock=1, even with s_req=0. It exits to IDLE when s_lock=0 and there is no sorter grant.
- wait_cnt:
  - Increments (saturating at 255) each cycle h_req=1 and h_gnt=0.
  - Clears on h_gnt or on h_req=0.
- Lock watchdog:
  - lock_cnt increments each cycle in SORT_LOCKED and clears on leaving it.
  - When lock_cnt reaches LOCK_MAX-1 and the lock is still held, the next state is forced to IDLE and lock_err is set.
  - s_lock is then ignored until it is observed low for 1 cycle.
  - lock_err clears only on rst.
- Simultaneous events: if h_req, s_req, SORT_LOCKED and starvation all coincide, the lock wins.
- Reset mid-operation:
  - All state and pending rvalid are dropped asynchronously.
  - No m_wen pulse is emitted during or immediately after reset.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined: h_gnt_cnt and s_gnt_cnt are 16-bit counters incremented on each respective grant. They saturate at 16'hFFFF and clear on rst.
- When undefined: both ports remain and are tied to 0, and no counter flops are synthesized.

Decomposition:
- Package sort_arb_pkg:
  - state encoding (IDLE=0, SORT=1, HOST=2, SORT_LOCKED=3);
  - owner encoding (NONE, HOST, SORT);
  - counter widths (wait 8, stats 16).
- Sub-module sort_arb_sat_cnt: parameterized saturating counter with inc/clr. Used for wait_cnt, lock_cnt and the stats counters.

Test Plan:
- Host only: write addr 3 = 0x0000_00AA, then read addr 3 -> h_gnt in the same cycle as h_req; h_rvalid=1 one cycle later with h_rdata=0xAA.
- Both requesting continuously, both unlocked, MAX_WAIT=8 -> s_gnt for 8 cycles, then exactly 1 h_gnt, then the pattern repeats (host gets 1 of every 9 cycles).
- Sorter locks across read 5, read 6, write 5, write 6 while h_req is held -> h_gnt=0 through all 4 transfers even after wait_cnt>=8; h_gnt on the first cycle after s_lock drops.
- Sorter holds s_lock for 20 cycles with LOCK_MAX=16 -> forced IDLE after 16 locked cycles; lock_err=1; pending host granted next.
- Granted host read, then rst asserted in the following cycle -> h_rvalid=0, all outputs 0 immediately; m_wen never pulses.
- With ARB_STATS_EN, 5 host and 7 sorter grants -> h_gnt_cnt=5, s_gnt_cnt=7. Without the macro, both read 0.

Source files
------------

// File: rtl/sort_arb_pkg.sv
// Shared encodings and counter widths for the sort-array memory arbiter.
package sort_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SORT        = 2'd1,
    ST_HOST        = 2'd2,
    ST_SORT_LOCKED = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_SORT = 2'd2
  } rd_own_t;

  localparam int WAIT_W  = 8;
  localparam int STATS_W = 16;
  localparam int LOCK_W  = 16;

endpackage

// File: rtl/sort_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module sort_arb_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sort_mem_arbiter.sv
// Arbiter sharing the single-port sort array between the bubble-sort
// controller and the host load/unload port. Sorter has default priority,
// the host is guaranteed service after MAX_WAIT stalled cycles, and a
// sorter lock keeps read/compare/write pairs atomic under a watchdog.
// Optional grant statistics are built when ARB_STATS_EN is defined.
module sort_mem_arbiter
  import sort_arb_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8,
  parameter int MAX_WAIT  = 8,
  parameter int LOCK_MAX  = 16
) (
  input  logic                 c_clk,
  input  logic                 rst,
  input  logic                 h_req,
  input  logic                 h_wen,
  input  logic [ADDRWIDTH-1:0] h_addr,
  input  logic [DATAWIDTH-1:0] h_wdata,
  output logic                 h_gnt,
  output logic [DATAWIDTH-1:0] h_rdata,
  output logic                 h_rvalid,
  input  logic                 s_req,
  input  logic                 s_wen,
  input  logic                 s_lock,
  input  logic [ADDRWIDTH-1:0] s_addr,
  input  logic [DATAWIDTH-1:0] s_wdata,
  output logic                 s_gnt,
  output logic [DATAWIDTH-1:0] s_rdata,
  output logic                 s_rvalid,
  output logic                 m_ren,
  output logic                 m_wen,
  output logic [ADDRWIDTH-1:0] m_addr,
  output logic [DATAWIDTH-1:0] m_wdata,
  input  logic [DATAWIDTH-1:0] m_rdata,
  output logic                 lock_err,
  output logic [15:0]          h_gnt_cnt,
  output logic [15:0]          s_gnt_cnt
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_MAX - 1);

  arb_state_t        state_q, state_d;
  rd_own_t           rd_own_q, rd_own_d;
  logic              lock_err_q, lock_err_d;
  logic              lock_ign_q, lock_ign_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              locked;
  logic              eff_lock;

  assign locked   = (state_q == ST_SORT_LOCKED);
  // After a watchdog release the sorter's lock request is disregarded
  // until it has been seen low, so a stuck s_lock cannot re-lock at once.
  assign eff_lock = s_lock & ~lock_ign_q;

  // Grant selection: lock, then host starvation, then sorter, then host.
  // Grants are suppressed while reset is asserted so no write escapes.
  always_comb begin
    h_gnt = 1'b0;
    s_gnt = 1'b0;
    if (!rst) begin
      if (locked) begin
        s_gnt = s_req;
      end else if (h_req && (wait_cnt >= MAX_WAIT_C)) begin
        h_gnt = 1'b1;
      end else if (s_req) begin
        s_gnt = 1'b1;
      end else if (h_req) begin
        h_gnt = 1'b1;
      end
    end
  end

  // Next state, lock watchdog and read-owner tracking.
  always_comb begin
    state_d    = ST_IDLE;
    lock_err_d = lock_err_q;
    lock_ign_d = lock_ign_q & s_lock;
    rd_own_d   = OWN_NONE;
    if (h_gnt) begin
      state_d = ST_HOST;
    end else if (s_gnt) begin
      state_d = eff_lock ? ST_SORT_LOCKED : ST_SORT;
    end else if (locked && eff_lock) begin
      state_d = ST_SORT_LOCKED;
    end
    if (locked && (lock_cnt == LOCK_LAST) && (state_d == ST_SORT_LOCKED)) begin
      state_d    = ST_IDLE;
      lock_err_d = 1'b1;
      lock_ign_d = 1'b1;
    end
    if (h_gnt && !h_wen) begin
      rd_own_d = OWN_HOST;
    end else if (s_gnt && !s_wen) begin
      rd_own_d = OWN_SORT;
    end
  end

  // Control registers.
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_own_q   <= OWN_NONE;
      lock_err_q <= 1'b0;
      lock_ign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_own_q   <= rd_own_d;
      lock_err_q <= lock_err_d;
      lock_ign_q <= lock_ign_d;
    end
  end

  // Memory port follows whichever requester holds the grant.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    if (h_gnt) begin
      m_addr  = h_addr;
      m_wdata = h_wdata;
    end else if (s_gnt) begin
      m_addr  = s_addr;
      m_wdata = s_wdata;
    end
    m_ren = (h_gnt & ~h_wen) | (s_gnt & ~s_wen);
    m_wen = (h_gnt & h_wen) | (s_gnt & s_wen);
  end

  // Read data is steered to the owner of last cycle's read only.
  always_comb begin
    h_rvalid = (rd_own_q == OWN_HOST);
    s_rvalid = (rd_own_q == OWN_SORT);
    h_rdata  = h_rvalid ? m_rdata : '0;
    s_rdata  = s_rvalid ? m_rdata : '0;
  end

  assign lock_err = lock_err_q;

  sort_arb_sat_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk (c_clk),
    .rst (rst),
    .inc (h_req & ~h_gnt),
    .clr (h_gnt | ~h_req),
    .cnt (wait_cnt)
  );

  sort_arb_sat_cnt #(.W(LOCK_W)) u_lock_cnt (
    .clk (c_clk),
    .rst (rst),
    .inc (locked),
    .clr (state_d != ST_SORT_LOCKED),
    .cnt (lock_cnt)
  );

`ifdef ARB_STATS_EN
  sort_arb_sat_cnt #(.W(STATS_W)) u_h_gnt_cnt (
    .clk (c_clk),
    .rst (rst),
    .inc (h_gnt),
    .clr (1'b0),
    .cnt (h_gnt_cnt)
  );

  sort_arb_sat_cnt #(.W(STATS_W)) u_s_gnt_cnt (
    .clk (c_clk),
    .rst (rst),
    .inc (s_gnt),
    .clr (1'b0),
    .cnt (s_gnt_cnt)
  );
`else
  assign h_gnt_cnt = '0;
  assign s_gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_sort_mem_arbiter.sv
// Directed bench for sort_mem_arbiter: a per-cycle vector table for the
// basic host/sorter traffic plus hand-written lock, starvation, watchdog,
// reset and statistics sequences. A small memory answers the m_* port.
module tb_sort_mem_arbiter;

  logic        c_clk;
  logic        rst;
  logic        h_req, h_wen;
  logic [7:0]  h_addr;
  logic [31:0] h_wdata;
  logic        h_gnt;
  logic [31:0] h_rdata;
  logic        h_rvalid;
  logic        s_req, s_wen, s_lock;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_gnt;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        m_ren, m_wen;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        lock_err;
  logic [15:0] h_gnt_cnt, s_gnt_cnt;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  sort_mem_arbiter #(
    .DATAWIDTH(32), .ADDRWIDTH(8), .MAX_WAIT(8), .LOCK_MAX(16)
  ) dut (
    .c_clk(c_clk), .rst(rst),
    .h_req(h_req), .h_wen(h_wen), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .s_req(s_req), .s_wen(s_wen), .s_lock(s_lock), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_gnt(s_gnt), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .lock_err(lock_err),
    .h_gnt_cnt(h_gnt_cnt), .s_gnt_cnt(s_gnt_cnt)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // Single-port memory with one-cycle read latency.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    m_rdata = 32'h0;
  end
  always @(posedge c_clk) begin
    if (m_wen) mem[m_addr] <= m_wdata;
    if (m_ren) m_rdata <= mem[m_addr];
  end

  typedef struct {
    logic        hr, hw;
    logic [7:0]  ha;
    logic [31:0] hd;
    logic        sr, sw, sl;
    logic [7:0]  sa;
    logic [31:0] sd;
    logic        ehg, esg, eren, ewen;
    logic [7:0]  eaddr;
    logic [31:0] ewd;
    logic        ehrv;
    logic [31:0] ehrd;
    logic        esrv;
    logic [31:0] esrd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge c_clk);
    #1;
  endtask

  task automatic idle_in();
    h_req = 1'b0; h_wen = 1'b0; h_addr = 8'h0; h_wdata = 32'h0;
    s_req = 1'b0; s_wen = 1'b0; s_lock = 1'b0; s_addr = 8'h0; s_wdata = 32'h0;
  endtask

  initial begin
    // Row layout: host inputs | sorter inputs | expected gnt/mem | expected read returns
    tbl[0] = '{1'b1,1'b1,8'd3,32'hAA, 1'b0,1'b0,1'b0,8'd0,32'h0,  1'b1,1'b0,1'b0,1'b1,8'd3,32'hAA, 1'b0,32'h0,  1'b0,32'h0};
    tbl[1] = '{1'b1,1'b0,8'd3,32'h0,  1'b0,1'b0,1'b0,8'd0,32'h0,  1'b1,1'b0,1'b1,1'b0,8'd3,32'h0,  1'b0,32'h0,  1'b0,32'h0};
    tbl[2] = '{1'b0,1'b0,8'd0,32'h0,  1'b0,1'b0,1'b0,8'd0,32'h0,  1'b0,1'b0,1'b0,1'b0,8'd0,32'h0,  1'b1,32'hAA, 1'b0,32'h0};
    tbl[3] = '{1'b0,1'b0,8'd0,32'h0,  1'b1,1'b1,1'b0,8'd5,32'h55, 1'b0,1'b1,1'b0,1'b1,8'd5,32'h55, 1'b0,32'h0,  1'b0,32'h0};
    tbl[4] = '{1'b0,1'b0,8'd0,32'h0,  1'b1,1'b0,1'b0,8'd5,32'h0,  1'b0,1'b1,1'b1,1'b0,8'd5,32'h0,  1'b0,32'h0,  1'b0,32'h0};
    tbl[5] = '{1'b1,1'b0,8'd3,32'h0,  1'b0,1'b0,1'b0,8'd0,32'h0,  1'b1,1'b0,1'b1,1'b0,8'd3,32'h0,  1'b0,32'h0,  1'b1,32'h55};
    tbl[6] = '{1'b1,1'b0,8'd5,32'h0,  1'b1,1'b0,1'b0,8'd3,32'h0,  1'b0,1'b1,1'b1,1'b0,8'd3,32'h0,  1'b1,32'hAA, 1'b0,32'h0};
    tbl[7] = '{1'b1,1'b0,8'd5,32'h0,  1'b0,1'b0,1'b0,8'd0,32'h0,  1'b1,1'b0,1'b1,1'b0,8'd5,32'h0,  1'b0,32'h0,  1'b1,32'hAA};
    tbl[8] = '{1'b0,1'b0,8'd0,32'h0,  1'b0,1'b0,1'b0,8'd0,32'h0,  1'b0,1'b0,1'b0,1'b0,8'd0,32'h0,  1'b1,32'h55, 1'b0,32'h0};

    // Reset state
    idle_in();
    rst = 1'b1;
    #12;
    chk("rst_h_gnt", 32'(h_gnt), 32'h0);
    chk("rst_s_gnt", 32'(s_gnt), 32'h0);
    chk("rst_m_ren", 32'(m_ren), 32'h0);
    chk("rst_m_wen", 32'(m_wen), 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'h0);
    chk("rst_h_rvalid", 32'(h_rvalid), 32'h0);
    chk("rst_s_rvalid", 32'(s_rvalid), 32'h0);
    chk("rst_lock_err", 32'(lock_err), 32'h0);
    chk("rst_h_gnt_cnt", 32'(h_gnt_cnt), 32'h0);
    chk("rst_s_gnt_cnt", 32'(s_gnt_cnt), 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // Table-driven basic traffic
    for (int r = 0; r < 9; r++) begin
      h_req = tbl[r].hr; h_wen = tbl[r].hw; h_addr = tbl[r].ha; h_wdata = tbl[r].hd;
      s_req = tbl[r].sr; s_wen = tbl[r].sw; s_lock = tbl[r].sl; s_addr = tbl[r].sa; s_wdata = tbl[r].sd;
      #2;
      chk($sformatf("row%0d_h_gnt", r), 32'(h_gnt), 32'(tbl[r].ehg));
      chk($sformatf("row%0d_s_gnt", r), 32'(s_gnt), 32'(tbl[r].esg));
      chk($sformatf("row%0d_m_ren", r), 32'(m_ren), 32'(tbl[r].eren));
      chk($sformatf("row%0d_m_wen", r), 32'(m_wen), 32'(tbl[r].ewen));
      chk($sformatf("row%0d_m_addr", r), 32'(m_addr), 32'(tbl[r].eaddr));
      chk($sformatf("row%0d_m_wdata", r), m_wdata, tbl[r].ewd);
      chk($sformatf("row%0d_h_rvalid", r), 32'(h_rvalid), 32'(tbl[r].ehrv));
      chk($sformatf("row%0d_h_rdata", r), h_rdata, tbl[r].ehrd);
      chk($sformatf("row%0d_s_rvalid", r), 32'(s_rvalid), 32'(tbl[r].esrv));
      chk($sformatf("row%0d_s_rdata", r), s_rdata, tbl[r].esrd);
      cyc();
    end

    // Both requesting, unlocked: host gets one cycle in nine
    for (int i = 0; i < 27; i++) begin
      h_req = 1'b1; h_wen = 1'b0; h_addr = 8'd1;
      s_req = 1'b1; s_wen = 1'b0; s_lock = 1'b0; s_addr = 8'd2;
      #2;
      chk($sformatf("starve%0d_h_gnt", i), 32'(h_gnt), 32'((i % 9) == 8));
      chk($sformatf("starve%0d_s_gnt", i), 32'(s_gnt), 32'((i % 9) != 8));
      cyc();
    end
    idle_in();
    cyc();

    // Locked read/read/write/write with host waiting past MAX_WAIT
    for (int c = 0; c <= 10; c++) begin
      h_req = 1'b1; h_wen = 1'b0; h_addr = 8'd7; h_wdata = 32'h0;
      s_req  = (c == 0) || (c == 4) || (c == 8) || (c == 9);
      s_lock = (c <= 8);
      s_wen  = (c >= 8);
      s_addr = ((c == 4) || (c == 9)) ? 8'd6 : 8'd5;
      s_wdata = (c == 8) ? 32'h1111 : ((c == 9) ? 32'h2222 : 32'h0);
      #2;
      chk($sformatf("lock%0d_h_gnt", c), 32'(h_gnt), 32'(c == 10));
      chk($sformatf("lock%0d_s_gnt", c), 32'(s_gnt), 32'((c == 0) || (c == 4) || (c == 8) || (c == 9)));
      cyc();
    end
    idle_in();
    cyc();

    // Stuck lock: watchdog forces release after 16 locked cycles
    for (int c = 0; c <= 20; c++) begin
      h_req  = (c <= 17) || (c == 19); h_wen = 1'b0; h_addr = 8'd3;
      s_req  = (c == 0) || (c == 18); s_wen = 1'b0; s_addr = 8'd5;
      s_lock = (c <= 19);
      #2;
      chk($sformatf("wdog%0d_h_gnt", c), 32'(h_gnt), 32'((c == 17) || (c == 19)));
      chk($sformatf("wdog%0d_s_gnt", c), 32'(s_gnt), 32'((c == 0) || (c == 18)));
      chk($sformatf("wdog%0d_lock_err", c), 32'(lock_err), 32'(c >= 17));
      cyc();
    end
    idle_in();
    cyc();

    // Reset right after a granted host read
    h_req = 1'b1; h_wen = 1'b0; h_addr = 8'd3;
    #2;
    chk("rstseq_h_gnt", 32'(h_gnt), 32'h1);
    cyc();
    h_req = 1'b0;
    #1;
    chk("rstseq_pending_rvalid", 32'(h_rvalid), 32'h1);
    rst = 1'b1;
    h_req = 1'b1; h_wen = 1'b1; h_addr = 8'd9; h_wdata = 32'hDEAD;
    s_req = 1'b1; s_wen = 1'b1; s_addr = 8'd4; s_wdata = 32'hBEEF;
    #1;
    chk("rstseq_h_rvalid", 32'(h_rvalid), 32'h0);
    chk("rstseq_h_rdata", h_rdata, 32'h0);
    chk("rstseq_h_gnt0", 32'(h_gnt), 32'h0);
    chk("rstseq_s_gnt0", 32'(s_gnt), 32'h0);
    chk("rstseq_m_wen0", 32'(m_wen), 32'h0);
    chk("rstseq_m_ren0", 32'(m_ren), 32'h0);
    chk("rstseq_m_addr0", 32'(m_addr), 32'h0);
    chk("rstseq_m_wdata0", m_wdata, 32'h0);
    chk("rstseq_lock_err", 32'(lock_err), 32'h0);
    cyc();
    chk("rstseq_m_wen1", 32'(m_wen), 32'h0);
    idle_in();
    rst = 1'b0;
    #2;
    chk("rstseq_m_wen2", 32'(m_wen), 32'h0);
    chk("rstseq_h_rvalid2", 32'(h_rvalid), 32'h0);
    cyc();
    chk("rstseq_m_wen3", 32'(m_wen), 32'h0);
    chk("rstseq_s_rvalid3", 32'(s_rvalid), 32'h0);

    // Grant statistics: 5 host and 7 sorter grants
    for (int i = 0; i < 5; i++) begin
      h_req = 1'b1; h_wen = 1'b0; h_addr = 8'(i);
      cyc();
    end
    idle_in();
    for (int i = 0; i < 7; i++) begin
      s_req = 1'b1; s_wen = 1'b0; s_addr = 8'(i);
      cyc();
    end
    idle_in();
    #2;
    chk("stats_h_gnt_cnt", 32'(h_gnt_cnt), STATS ? 32'd5 : 32'd0);
    chk("stats_s_gnt_cnt", 32'(s_gnt_cnt), STATS ? 32'd7 : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
